// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths, config word layout and channel map for the ADC responder
package adc_pkg;

    localparam int CFG_W  = 6;
    localparam int DATA_W = 12;
    localparam int NUM_CH = 8;

    // Config word as shifted in by the initiator, MSB first: {S/D, O/S, S1, S0, UNI, SLP}
    typedef struct packed {
        logic sd;
        logic os;
        logic s1;
        logic s0;
        logic uni;
        logic slp;
    } cfg_t;

    // Single-ended, channel 0, unipolar, awake
    localparam cfg_t CFG_RESET = 6'b100010;

    // Unipolar-to-two's-complement conversion flips the MSB
    localparam logic [DATA_W-1:0] BIPOLAR_FLIP = 12'h800;

    // Frame progress seen from the serial side
    typedef enum logic [1:0] {
        FR_IDLE  = 2'd0,
        FR_SHIFT = 2'd1,
        FR_TAIL  = 2'd2
    } frame_state_t;

    // {O/S,S1,S0} -> channel: even channels when O/S=0, odd when O/S=1,
    // which is a one-bit rotate of the select field
    function automatic logic [2:0] chan_of(input logic [2:0] sel);
        return {sel[1:0], sel[2]};
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with one-cycle rise/fall pulses
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - SPI-style 8-channel ADC model: config in, 12-bit sample out
module adc_responder
    import adc_pkg::*;
#(
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iCS,
    input  logic                     iSCLK,
    input  logic                     iDIN,
    output logic                     oDOUT,
    input  logic [DATA_W*NUM_CH-1:0] iCH_DATA,
    output logic                     oBUSY,
    output logic                     oFRAME_DONE,
    output logic [CFG_W-1:0]         oCFG,
    output logic                     oERR
);

    localparam int         CNT_W    = $clog2(CONV_CYCLES + 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
    localparam logic [2:0] CFG_FULL = 3'(CFG_W);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] din_sync;
    logic din_s;

    frame_state_t state, state_n;
    logic shift_bit;
    logic in_frame, cs_low, fall_valid, rise_valid;

    cfg_t              active_cfg, pend_cfg, eff_cfg;
    logic [2:0]        cfg_cnt;
    logic [2:0]        ch_sel;
    logic [DATA_W-1:0] raw, conv_sample, sample;
    logic [3:0]        bit_idx, bit_idx_m1;
    logic              dout_q, zero_frame, frame_done, err;
    logic [CNT_W-1:0]  conv_cnt;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .iCLK (iCLK),
        .iRST (iRST),
        .d    (iCS),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .iCLK (iCLK),
        .iRST (iRST),
        .d    (iSCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // DIN only needs to line up with the SCLK edges, so it gets the same depth
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            din_sync <= '0;
        end else begin
            din_sync[0] <= iDIN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                din_sync[i] <= din_sync[i-1];
            end
        end
    end

    assign din_s = din_sync[SYNC_STAGES-1];

    // The frame state doubles as the synchronized chip-select level;
    // the edge pulses cover the single cycle before the state catches up
    assign in_frame   = (state != FR_IDLE);
    assign cs_low     = (in_frame & ~cs_rise) | cs_fall;
    assign fall_valid = sclk_fall & cs_low;
    assign rise_valid = sclk_rise & cs_low;
    assign bit_idx_m1 = bit_idx - 4'd1;

    // Frame state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= FR_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame sequencing: start on CS fall, walk 12 bits on SCLK falls, rest until CS rise
    always_comb begin
        state_n   = state;
        shift_bit = 1'b0;
        if (cs_fall) begin
            state_n = FR_SHIFT;
        end else if (cs_rise) begin
            state_n = FR_IDLE;
        end else if (state == FR_SHIFT && sclk_fall) begin
            if (bit_idx == '0) begin
                state_n = FR_TAIL;
            end else begin
                shift_bit = 1'b1;
            end
        end
    end

    // Conversion result for a start right now, with a complete pending config taking effect first
    always_comb begin
        eff_cfg = (cfg_cnt >= CFG_FULL) ? pend_cfg : active_cfg;
        ch_sel  = chan_of({eff_cfg.os, eff_cfg.s1, eff_cfg.s0});
        raw     = iCH_DATA[ch_sel*DATA_W +: DATA_W];
        if (!eff_cfg.sd || eff_cfg.slp) begin
            conv_sample = '0;
        end else if (eff_cfg.uni) begin
            conv_sample = raw;
        end else begin
            conv_sample = raw ^ BIPOLAR_FLIP;
        end
    end

    // Serial shift-out, config capture, conversion timer and status pulses
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            active_cfg <= CFG_RESET;
            pend_cfg   <= CFG_RESET;
            cfg_cnt    <= '0;
            sample     <= '0;
            bit_idx    <= LAST_BIT;
            dout_q     <= 1'b0;
            zero_frame <= 1'b0;
            conv_cnt   <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= cs_rise;
            err        <= ((sclk_rise | sclk_fall) & ~cs_low) | (cs_fall & oBUSY);

            if (cs_fall) begin
                // A frame opened during a conversion has no valid data to offer
                bit_idx    <= LAST_BIT;
                cfg_cnt    <= '0;
                zero_frame <= oBUSY;
                dout_q     <= ~oBUSY & sample[LAST_BIT];
            end else if (fall_valid) begin
                if (shift_bit) begin
                    bit_idx <= bit_idx_m1;
                    dout_q  <= ~zero_frame & sample[bit_idx_m1];
                end else begin
                    dout_q  <= 1'b0;
                end
            end

            if (rise_valid && cfg_cnt < CFG_FULL) begin
                pend_cfg <= {pend_cfg[CFG_W-2:0], din_s};
                cfg_cnt  <= cfg_cnt + 3'd1;
            end

            if (cs_rise) begin
                active_cfg <= eff_cfg;
                sample     <= conv_sample;
                conv_cnt   <= CNT_W'(CONV_CYCLES);
                dout_q     <= 1'b0;
            end else if (conv_cnt != '0) begin
                conv_cnt <= conv_cnt - CNT_W'(1);
            end
        end
    end

    assign oDOUT       = dout_q & cs_low;
    assign oBUSY       = (conv_cnt != '0);
    assign oFRAME_DONE = frame_done;
    assign oCFG        = active_cfg;
    assign oERR        = err;

endmodule

// File: tb/tb_adc_responder.sv
// tb/tb_adc_responder.sv - self-checking bench for adc_responder
module tb_adc_responder;

    localparam int         CONV    = 80;
    localparam int         SYNC    = 2;
    localparam logic [5:0] CFG_RST = 6'b100010;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iCS = 1'b1;
    logic        iSCLK = 1'b0;
    logic        iDIN = 1'b0;
    logic [95:0] iCH_DATA = '0;
    logic        oDOUT, oBUSY, oFRAME_DONE, oERR;
    logic [5:0]  oCFG;

    adc_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(SYNC)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iCS         (iCS),
        .iSCLK       (iSCLK),
        .iDIN        (iDIN),
        .oDOUT       (oDOUT),
        .iCH_DATA    (iCH_DATA),
        .oBUSY       (oBUSY),
        .oFRAME_DONE (oFRAME_DONE),
        .oCFG        (oCFG),
        .oERR        (oERR)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    always @(posedge iCLK) begin
        if (oFRAME_DONE) fd_cnt++;
        if (oERR) err_cnt++;
    end

    // Reference state: active config, last converted sample, channel inputs
    logic [5:0]  m_cfg;
    logic [11:0] m_sample;
    logic [11:0] ch_vals [8];
    int          chan_tbl [8] = '{0, 2, 4, 6, 1, 3, 5, 7};

    typedef struct {
        logic [5:0]  cfg;
        int          ch;
        logic [11:0] val;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl [11];

    function automatic logic [11:0] model_sample(input logic [5:0] c);
        int v;
        if (!c[5] || c[0]) return 12'h000;
        v = int'(ch_vals[chan_tbl[c[4:2]]]);
        if (!c[1]) v = (v + 2048) % 4096;
        return 12'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic drive_ch();
        for (int i = 0; i < 8; i++) iCH_DATA[i*12 +: 12] = ch_vals[i];
    endtask

    task automatic rand_ch();
        for (int i = 0; i < 8; i++) ch_vals[i] = 12'($urandom);
        drive_ch();
    endtask

    task automatic run_frame(input logic [5:0] cfg, input int n_clk, input bit exp_zero,
                             input bit meas_busy, input bit mix_ch, output logic [11:0] bits);
        logic [11:0] exp;
        logic        tail;
        int          fd0, er0, n;
        exp  = exp_zero ? 12'h000 : m_sample;
        fd0  = fd_cnt;
        er0  = err_cnt;
        bits = '0;
        iCS  = 1'b0;
        tick(SYNC + 3);
        for (int i = 0; i < n_clk; i++) begin
            if (i < 12) bits[11-i] = oDOUT;
            if (mix_ch && i == 6) rand_ch();
            iDIN = (i < 6) ? cfg[5-i] : 1'b0;
            tick(1);
            iSCLK = 1'b1;
            tick(4);
            iSCLK = 1'b0;
            tick(4);
        end
        tail = oDOUT;
        if (n_clk >= 12) begin
            check("dout_word", 32'(bits), 32'(exp));
            check("dout_tail", 32'(tail), 0);
        end else begin
            check("dout_partial", 32'(bits >> (12 - n_clk)), 32'(exp >> (12 - n_clk)));
        end
        iCS = 1'b1;
        if (n_clk >= 6) m_cfg = cfg;
        m_sample = model_sample(m_cfg);
        if (meas_busy) begin
            n = 0;
            for (int k = 0; k < 10 && !oBUSY; k++) tick(1);
            while (oBUSY && n < 200) begin
                n++;
                tick(1);
            end
            check("busy_cycles", n, CONV);
        end else begin
            tick(SYNC + 3);
        end
        check("frame_done", fd_cnt - fd0, 1);
        check("cfg_active", 32'(oCFG), 32'(m_cfg));
        check("err_pulses", err_cnt - er0, exp_zero ? 1 : 0);
        check("dout_idle", 32'(oDOUT), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [11:0] bits;
        logic [5:0]  c;
        int          e0;

        tbl[0]  = '{6'b111110, 7, 12'h123, 12'h123};
        tbl[1]  = '{6'b111100, 7, 12'h123, 12'h923};
        tbl[2]  = '{6'b111111, 7, 12'h123, 12'h000};
        tbl[3]  = '{6'b111110, 7, 12'h123, 12'h123};
        tbl[4]  = '{6'b011110, 7, 12'h456, 12'h000};
        tbl[5]  = '{6'b110010, 1, 12'h5A5, 12'h5A5};
        tbl[6]  = '{6'b101010, 4, 12'h7FF, 12'h7FF};
        tbl[7]  = '{6'b101000, 4, 12'h7FF, 12'hFFF};
        tbl[8]  = '{6'b100000, 0, 12'hABC, 12'h2BC};
        tbl[9]  = '{6'b100110, 2, 12'h001, 12'h001};
        tbl[10] = '{6'b111010, 5, 12'h800, 12'h800};

        m_cfg    = CFG_RST;
        m_sample = 12'h000;
        for (int i = 0; i < 8; i++) ch_vals[i] = 12'h000;
        drive_ch();

        // Reset state
        iRST = 1'b1;
        tick(4);
        check("rst_dout", 32'(oDOUT), 0);
        check("rst_busy", 32'(oBUSY), 0);
        check("rst_frame_done", 32'(oFRAME_DONE), 0);
        check("rst_err", 32'(oERR), 0);
        check("rst_cfg", 32'(oCFG), 32'(CFG_RST));
        iRST = 1'b0;
        tick(3);

        // First frame reads the reset sample; default config converts ch0
        ch_vals[0] = 12'hABC;
        drive_ch();
        run_frame(CFG_RST, 12, 0, 1, 0, bits);
        check("first_frame_zero", 32'(bits), 0);
        run_frame(6'b111110, 12, 0, 1, 0, bits);
        check("ch0_abc", 32'(bits), 32'h0ABC);
        check("cfg_111110", 32'(oCFG), 32'h3E);

        // Table: commit config and latch channel, then read it back in the next frame
        for (int t = 0; t < 11; t++) begin
            ch_vals[tbl[t].ch] = tbl[t].val;
            drive_ch();
            run_frame(tbl[t].cfg, 12, 0, 1, 0, bits);
            run_frame(tbl[t].cfg, 12, 0, 1, 0, bits);
            check($sformatf("tbl%0d_dout", t), 32'(bits), 32'(tbl[t].exp));
        end

        // Short config: only 4 bits, active config must stay
        run_frame(6'b000001, 4, 0, 1, 0, bits);
        check("short_cfg_kept", 32'(oCFG), 32'h3A);
        run_frame(6'b111010, 12, 0, 1, 0, bits);

        // Frame opened 20 cycles into a conversion
        run_frame(6'b111110, 12, 0, 0, 0, bits);
        tick(15);
        run_frame(6'b111110, 12, 1, 0, 0, bits);
        check("busy_frame_zero", 32'(bits), 0);
        tick(CONV + 20);
        check("busy_done", 32'(oBUSY), 0);

        // SCLK toggling with CS high
        e0 = err_cnt;
        iSCLK = 1'b1;
        tick(5);
        iSCLK = 1'b0;
        tick(5);
        check("idle_sclk_err", err_cnt - e0, 2);
        check("idle_sclk_cfg", 32'(oCFG), 32'(m_cfg));
        check("idle_sclk_busy", 32'(oBUSY), 0);
        check("idle_sclk_dout", 32'(oDOUT), 0);
        run_frame(6'b111110, 12, 0, 1, 0, bits);

        // Randomized frames against the reference model, channel data changed mid-frame
        for (int r = 0; r < 30; r++) begin
            c = 6'($urandom);
            if ($urandom_range(3) != 0) begin
                c[5] = 1'b1;
                c[0] = 1'b0;
            end
            rand_ch();
            run_frame(c, 12, 0, 1, 1, bits);
        end

        // Reset after the 5th SCLK falling edge
        iCS = 1'b0;
        tick(SYNC + 3);
        for (int i = 0; i < 5; i++) begin
            iDIN = 1'b1;
            tick(1);
            iSCLK = 1'b1;
            tick(4);
            iSCLK = 1'b0;
            tick(4);
        end
        iRST = 1'b1;
        iCS  = 1'b1;
        tick(1);
        check("mid_rst_dout", 32'(oDOUT), 0);
        check("mid_rst_busy", 32'(oBUSY), 0);
        check("mid_rst_cfg", 32'(oCFG), 32'(CFG_RST));
        check("mid_rst_err", 32'(oERR), 0);
        check("mid_rst_fd", 32'(oFRAME_DONE), 0);
        tick(4);
        iRST = 1'b0;
        tick(3);
        m_cfg    = CFG_RST;
        m_sample = 12'h000;
        for (int i = 0; i < 8; i++) ch_vals[i] = 12'h000;
        ch_vals[0] = 12'h3C5;
        drive_ch();
        run_frame(CFG_RST, 12, 0, 1, 0, bits);
        check("post_rst_zero", 32'(bits), 0);
        run_frame(CFG_RST, 12, 0, 1, 0, bits);
        check("post_rst_data", 32'(bits), 32'h03C5);
        check("post_rst_cfg", 32'(oCFG), 32'(CFG_RST));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
